// File: rtl/ifid_skid_stage.sv
// IF/ID pipeline register with valid/ready handshake, optional skid entry,
// flush-to-NOP and a global step enable.
module ifid_skid_stage #(
    parameter int unsigned       DATA_W   = 32,
    parameter int unsigned       PC_W     = 32,
    parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(32'hF800_0000),
    parameter bit                SKID     = 1'b1
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              ENABLE,
    input  logic              I_FLUSH,
    input  logic              I_VALID,
    input  logic [DATA_W-1:0] I_INSTRUCTION,
    input  logic [PC_W-1:0]   I_PC,
    output logic              O_READY,
    output logic              O_VALID,
    output logic [DATA_W-1:0] O_INSTRUCTION,
    output logic [PC_W-1:0]   O_PC,
    input  logic              I_READY,
    output logic [1:0]        O_COUNT
);

    // Encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] main_ins_q, main_ins_d;
    logic [PC_W-1:0]   main_pc_q, main_pc_d;
    logic [DATA_W-1:0] skid_ins_q, skid_ins_d;
    logic [PC_W-1:0]   skid_pc_q, skid_pc_d;
    logic              ready_s;
    logic              push_s;
    logic              pop_s;

    // Ready: from state only with a skid entry, else passes I_READY through.
    always_comb begin
        ready_s = 1'b0;
        if (SKID) begin
            ready_s = (state_q != ST_SKID);
        end else begin
            ready_s = !valid_q || I_READY;
        end
    end

    assign push_s = ENABLE && I_VALID && ready_s;
    assign pop_s  = ENABLE && valid_q && I_READY;

    // Next-state and datapath; an empty main entry always holds the bubble.
    always_comb begin
        state_d    = state_q;
        main_ins_d = main_ins_q;
        main_pc_d  = main_pc_q;
        skid_ins_d = skid_ins_q;
        skid_pc_d  = skid_pc_q;
        if (!ENABLE) begin
            state_d = state_q;
        end else if (I_FLUSH) begin
            state_d    = ST_EMPTY;
            main_ins_d = NOP_WORD;
            main_pc_d  = {PC_W{1'b0}};
            skid_ins_d = NOP_WORD;
            skid_pc_d  = {PC_W{1'b0}};
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (push_s) begin
                        state_d    = ST_FULL;
                        main_ins_d = I_INSTRUCTION;
                        main_pc_d  = I_PC;
                    end else begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (push_s && pop_s) begin
                        main_ins_d = I_INSTRUCTION;
                        main_pc_d  = I_PC;
                    end else if (push_s) begin
                        if (SKID) begin
                            state_d    = ST_SKID;
                            skid_ins_d = I_INSTRUCTION;
                            skid_pc_d  = I_PC;
                        end else begin
                            main_ins_d = I_INSTRUCTION;
                            main_pc_d  = I_PC;
                        end
                    end else if (pop_s) begin
                        state_d    = ST_EMPTY;
                        main_ins_d = NOP_WORD;
                        main_pc_d  = {PC_W{1'b0}};
                    end else begin
                        state_d = ST_FULL;
                    end
                end
                ST_SKID: begin
                    if (pop_s) begin
                        state_d    = ST_FULL;
                        main_ins_d = skid_ins_q;
                        main_pc_d  = skid_pc_q;
                        skid_ins_d = NOP_WORD;
                        skid_pc_d  = {PC_W{1'b0}};
                    end else begin
                        state_d = ST_SKID;
                    end
                end
                default: begin
                    state_d    = ST_EMPTY;
                    main_ins_d = NOP_WORD;
                    main_pc_d  = {PC_W{1'b0}};
                    skid_ins_d = NOP_WORD;
                    skid_pc_d  = {PC_W{1'b0}};
                end
            endcase
        end
        valid_d = (state_d != ST_EMPTY);
    end

    // State and data registers.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q    <= ST_EMPTY;
            valid_q    <= 1'b0;
            main_ins_q <= NOP_WORD;
            main_pc_q  <= {PC_W{1'b0}};
            skid_ins_q <= NOP_WORD;
            skid_pc_q  <= {PC_W{1'b0}};
        end else begin
            state_q    <= state_d;
            valid_q    <= valid_d;
            main_ins_q <= main_ins_d;
            main_pc_q  <= main_pc_d;
            skid_ins_q <= skid_ins_d;
            skid_pc_q  <= skid_pc_d;
        end
    end

    assign O_READY       = ready_s;
    assign O_VALID       = valid_q;
    assign O_INSTRUCTION = main_ins_q;
    assign O_PC          = main_pc_q;
    assign O_COUNT       = state_q;

endmodule

// File: tb/tb_ifid_skid_stage.sv
// Bench for ifid_skid_stage: SKID=1 and SKID=0 instances share stimulus and
// are checked against a FIFO-queue model plus literal expectations.
module tb_ifid_skid_stage;

    localparam logic [31:0] NOP = 32'hF800_0000;

    typedef struct packed {
        logic [31:0] ins;
        logic [31:0] pc;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        fl = 1'b0;
    logic        iv = 1'b0;
    logic [31:0] ins = 32'd0;
    logic [31:0] pc = 32'd0;
    logic        ir = 1'b0;

    logic        rdy [2];
    logic        ov [2];
    logic [31:0] oins [2];
    logic [31:0] opc [2];
    logic [1:0]  cnt [2];

    int compared = 0;
    int mismatched = 0;

    beat_t mq [2][$];

    always #5 clk = ~clk;

    ifid_skid_stage #(.DATA_W(32), .PC_W(32), .SKID(1'b0)) dut0 (
        .CLK(clk), .RESET_N(rst_n), .ENABLE(en), .I_FLUSH(fl), .I_VALID(iv),
        .I_INSTRUCTION(ins), .I_PC(pc), .O_READY(rdy[0]), .O_VALID(ov[0]),
        .O_INSTRUCTION(oins[0]), .O_PC(opc[0]), .I_READY(ir), .O_COUNT(cnt[0])
    );

    ifid_skid_stage #(.DATA_W(32), .PC_W(32), .SKID(1'b1)) dut1 (
        .CLK(clk), .RESET_N(rst_n), .ENABLE(en), .I_FLUSH(fl), .I_VALID(iv),
        .I_INSTRUCTION(ins), .I_PC(pc), .O_READY(rdy[1]), .O_VALID(ov[1]),
        .O_INSTRUCTION(oins[1]), .O_PC(opc[1]), .I_READY(ir), .O_COUNT(cnt[1])
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Model: instance i is a FIFO of capacity i+1 (1 for SKID=0, 2 for SKID=1).
    function automatic logic model_ready(input int i);
        if (i == 1) return (mq[1].size() < 2);
        return (mq[0].size() == 0) || ir;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq[0].delete();
            mq[1].delete();
        end else if (en) begin
            for (int i = 0; i < 2; i++) begin
                if (fl) begin
                    mq[i].delete();
                end else begin
                    logic do_push;
                    do_push = iv && model_ready(i);
                    if (mq[i].size() > 0 && ir) void'(mq[i].pop_front());
                    if (do_push) mq[i].push_back('{ins: ins, pc: pc});
                end
            end
        end
    end

    // Compare both instances against the model every falling edge.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            logic [31:0] e_ins, e_pc;
            logic        e_v, e_r;
            logic [1:0]  e_c;
            e_v   = (mq[i].size() > 0);
            e_ins = e_v ? mq[i][0].ins : NOP;
            e_pc  = e_v ? mq[i][0].pc : 32'd0;
            e_c   = 2'(mq[i].size());
            e_r   = model_ready(i);
            compared++;
            if (ov[i] !== e_v || oins[i] !== e_ins || opc[i] !== e_pc ||
                cnt[i] !== e_c || rdy[i] !== e_r) begin
                mismatched++;
                $display("FAIL model_cmp skid%0d: got v=%b ins=%h pc=%h cnt=%0d rdy=%b expected v=%b ins=%h pc=%h cnt=%0d rdy=%b at %0t",
                         i, ov[i], oins[i], opc[i], cnt[i], rdy[i], e_v, e_ins, e_pc, e_c, e_r, $time);
            end
        end
    end

    // Apply one cycle of inputs, then return 2 time units after the edge.
    task automatic cyc(input logic v, input logic e, input logic f, input logic r, input logic [31:0] p);
        iv  = v;
        en  = e;
        fl  = f;
        ir  = r;
        pc  = p;
        ins = p ^ 32'h1357_9BDF;
        @(posedge clk);
        #2;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #2;
        check("reset_valid", {31'd0, ov[1]}, 32'd0);
        check("reset_ins", oins[1], NOP);
        check("reset_pc", opc[1], 32'd0);
        check("reset_cnt", {30'd0, cnt[1]}, 32'd0);
        rst_n = 1'b1;
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 32'd0);

        // Streaming with I_READY=1: each PC one cycle later, count stays 1.
        for (int k = 0; k < 4; k++) begin
            cyc(1'b1, 1'b1, 1'b0, 1'b1, 32'(k * 4));
            check("stream_pc", opc[1], 32'(k * 4));
            check("stream_ins", oins[1], 32'(k * 4) ^ 32'h1357_9BDF);
            check("stream_cnt", {30'd0, cnt[1]}, 32'd1);
            check("stream_pc_s0", opc[0], 32'(k * 4));
        end

        // Backpressure: 0x08 held, 0x0C in skid, then drain in order.
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 32'd0);
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 32'h00);
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 32'h04);
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 32'h08);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'h0C);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'h10);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'h10);
        check("bp_pc", opc[1], 32'h08);
        check("bp_cnt", {30'd0, cnt[1]}, 32'd2);
        check("bp_ready", {31'd0, rdy[1]}, 32'd0);
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 32'h10);
        check("drain_pc0", opc[1], 32'h0C);
        check("drain_ready", {31'd0, rdy[1]}, 32'd1);
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 32'h10);
        check("drain_pc1", opc[1], 32'h10);

        // Flush in SKID state with a concurrent push of 0x40.
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'h14);
        check("pre_flush_cnt", {30'd0, cnt[1]}, 32'd2);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 32'h40);
        check("flush_valid", {31'd0, ov[1]}, 32'd0);
        check("flush_ins", oins[1], NOP);
        check("flush_pc", opc[1], 32'd0);
        check("flush_cnt", {30'd0, cnt[1]}, 32'd0);
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 32'd0);
        check("flush_no40", {31'd0, ov[1]}, 32'd0);

        // ENABLE=0 freezes everything, even with flush/valid/ready high.
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'h50);
        for (int k = 0; k < 4; k++) begin
            cyc(1'b1, 1'b0, 1'b1, 1'b1, 32'h60);
            check("hold_pc", opc[1], 32'h50);
            check("hold_cnt", {30'd0, cnt[1]}, 32'd1);
        end
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 32'h64);
        check("resume_pc", opc[1], 32'h64);

        // SKID=0: combinational ready, simultaneous pop and push.
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 32'd0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'h1C);
        iv = 1'b1;
        ir = 1'b0;
        #1;
        check("s0_ready_low", {31'd0, rdy[0]}, 32'd0);
        ir = 1'b1;
        #1;
        check("s0_ready_comb", {31'd0, rdy[0]}, 32'd1);
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 32'h20);
        check("s0_pc20", opc[0], 32'h20);
        check("s0_cnt", {30'd0, cnt[0]}, 32'd1);

        // Asynchronous reset while in SKID state with I_VALID=1.
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'h70);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'h74);
        check("pre_rst_cnt", {30'd0, cnt[1]}, 32'd2);
        rst_n = 1'b0;
        #1;
        check("arst_valid", {31'd0, ov[1]}, 32'd0);
        check("arst_ins", oins[1], NOP);
        check("arst_pc", opc[1], 32'd0);
        check("arst_cnt", {30'd0, cnt[1]}, 32'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'h78);
        check("post_rst_pc", opc[1], 32'h78);
        check("post_rst_ready", {31'd0, rdy[1]}, 32'd1);

        // Randomised traffic checked by the model.
        for (int k = 0; k < 600; k++) begin
            iv  = ($urandom_range(0, 3) != 0);
            en  = ($urandom_range(0, 9) != 0);
            fl  = ($urandom_range(0, 19) == 0);
            ir  = ($urandom_range(0, 2) != 0);
            pc  = $urandom;
            ins = $urandom;
            @(posedge clk);
            #2;
        end

        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/ifid_skid_stage.md
# ifid_skid_stage

Parametrised IF/ID pipeline stage register with a valid/ready handshake, an optional two-entry skid buffer, flush-to-NOP and a global step enable. It sits between instruction fetch and decode and replaces the plain write-enable latch with elastic buffering. The skid entry removes the combinational ready path from decode back to fetch. Instruction and PC widths are parametrised so the same block serves the other front-end stage boundaries.

## Interface
- DATA_W, 32: instruction word width.
- PC_W, 32: PC width.
- NOP_WORD, 32'hF800_0000 (sized to DATA_W): bubble encoding driven whenever the output is invalid.
- SKID, 1: 1 = two entries (main + skid), registered O_READY; 0 = single entry, combinational O_READY.

Ports:
- CLK  in  1  rising-edge clock.
- RESET_N  in  1  asynchronous, active-low reset.
- ENABLE  in  1  global pipeline step; 0 freezes all state in every stage simultaneously.
- I_FLUSH  in  1  discard all held and incoming entries.
- I_VALID  in  1  upstream beat present.
- I_INSTRUCTION  in  DATA_W  upstream instruction.
- I_PC  in  PC_W  upstream PC.
- O_READY  out  1  stage can accept a beat.
- O_VALID  out  1  output beat present.
- O_INSTRUCTION  out  DATA_W  held instruction; NOP_WORD when O_VALID=0.
- O_PC  out  PC_W  held PC; 0 when O_VALID=0.
- I_READY  in  1  downstream accepts the output beat.
- O_COUNT  out  2  occupancy, 0..2 (0..1 when SKID=0).

## Operation
- Push = ENABLE & I_VALID & O_READY. Pop = ENABLE & O_VALID & I_READY.
- Reset (RESET_N=0, any time, mid-transfer included): both entries invalid, O_VALID=0, O_INSTRUCTION=NOP_WORD, O_PC=0, O_COUNT=0. O_READY=1 once reset is released.
- States (SKID=1): EMPTY (count 0), FULL (main valid, count 1), SKID (main and skid valid, count 2).
- EMPTY: push -> load main, go to FULL.
- FULL: push & !pop -> load skid, go to SKID. Push & pop -> load main, stay in FULL. Pop & !push -> go to EMPTY.
- SKID: pop -> move skid to main, clear skid, go to FULL. Push cannot occur in this state because O_READY=0.
- SKID=0: only EMPTY and FULL exist. O_READY = !O_VALID | I_READY. Push & pop in FULL replaces main.
- SKID=1: O_READY = !skid_valid, driven from a register with no dependency on I_READY.
- Flush (ENABLE=1, I_FLUSH=1):
  - All entries invalidated and any concurrent push dropped.
  - Next state EMPTY, outputs go to NOP_WORD/0, O_VALID=0.
  - Flush has priority over push and pop.
- ENABLE=0: no state change. Flush, push and pop are all ignored, and outputs hold.
- Output invariant: whenever main is invalid, O_INSTRUCTION=NOP_WORD and O_PC=0. Data is never stale.
- Beats leave in arrival order. There is no duplication or loss except on flush.

## Timing
- Latency: a beat pushed at edge N is visible at O_VALID/O_INSTRUCTION after edge N, so downstream can pop at edge N+1.
- Throughput: 1 beat/cycle sustained when I_READY=1, for both SKID values.
- Backpressure with SKID=1:
  - I_READY falls while streaming: one more beat is absorbed into skid, then O_READY=0 starting the following cycle.
  - I_READY returns: skid drains first. O_READY=1 one cycle after the draining pop.
- All outputs are registered except O_READY when SKID=0.
- Reset assertion is asynchronous. Deassertion takes effect at the next CLK edge.

## Test plan
- Reset mid-stream while in SKID state, with I_VALID=1 -> outputs immediately NOP_WORD/0, O_VALID=0, O_COUNT=0; O_READY=1 after release.
- Stream PCs 0x00,0x04,0x08,0x0C with I_READY=1, ENABLE=1 -> each appears one cycle later, in order; O_COUNT stays at 1 while streaming.
- SKID=1, streaming, I_READY=0 for 3 cycles -> PC 0x08 held at output, 0x0C in skid, O_READY=0, O_COUNT=2. On release, 0x08 then 0x0C then 0x10 appear, with no loss.
- In SKID state assert I_FLUSH together with I_VALID (PC 0x40) -> next cycle O_VALID=0, O_INSTRUCTION=0xF8000000, O_PC=0, O_COUNT=0; 0x40 never appears.
- ENABLE=0 for 4 cycles with I_VALID=1, I_READY=1, I_FLUSH=1 -> all outputs and O_COUNT unchanged; normal flow resumes when ENABLE=1.
- SKID=0, FULL, I_READY=0 -> O_READY=0 combinationally. Raise I_READY with I_VALID=1 (PC 0x20) in the same cycle -> pop and push together; PC 0x20 at output next cycle.
